// File: rtl/apb_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | apb_responder: APB completer with a word-addressed register bank, fixed  |
// | wait states and pslverr on decode errors. Optional protocol checker      |
// | built when APB_RESPONDER_PROTOCOL_CHECK_EN is defined.                   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module apb_responder #(
   parameter int                   ADDR_WIDTH  = 32,
   parameter int                   DATA_WIDTH  = 32,
   parameter int                   NUM_REGS    = 16,
   parameter int                   WAIT_CYCLES = 0,
   parameter logic [DATA_WIDTH-1:0] ID_VALUE   = 32'hA9B0_0001
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  psel,
   input  logic                  penable,
   input  logic [ADDR_WIDTH-1:0] paddr,
   input  logic                  pwrite,
   input  logic [DATA_WIDTH-1:0] pwdata,
   output logic [DATA_WIDTH-1:0] prdata,
   output logic                  pready,
   output logic                  pslverr,
   output logic                  proto_err
);

   localparam int AIW  = ADDR_WIDTH - 2;
   localparam int IDXW = $clog2(NUM_REGS);
   localparam logic [AIW-1:0] c_num_regs = AIW'(NUM_REGS);
   localparam logic [7:0]     c_wait     = 8'(WAIT_CYCLES);

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_ACCESS = 1'b1
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [7:0]            r_wcnt;
   logic [7:0]            w_wcnt_nxt;
   logic                  r_pready;
   logic                  w_pready_nxt;
   logic                  r_pslverr;
   logic                  w_pslverr_nxt;
   logic [DATA_WIDTH-1:0] r_prdata;
   logic [DATA_WIDTH-1:0] w_prdata_nxt;
   logic                  w_accept;
   logic                  w_wr_en;

   logic [IDXW-1:0]       r_index;
   logic                  r_pwrite;
   logic [DATA_WIDTH-1:0] r_pwdata;
   logic                  r_err;
   logic [DATA_WIDTH-1:0] r_rdata;

   logic [DATA_WIDTH-1:0] r_regs [1:NUM_REGS-1];

   logic [AIW-1:0]        w_addr_index;
   logic                  w_err;
   logic [DATA_WIDTH-1:0] w_rd_word;

   assign w_addr_index = paddr[ADDR_WIDTH-1:2];
   assign w_err = (paddr[1:0] != 2'b00) || !(w_addr_index < c_num_regs) ||
                  (pwrite && (w_addr_index == '0));

   always_comb begin
      w_rd_word = ID_VALUE;
      for (int i = 1; i < NUM_REGS; i++) begin
         if (w_addr_index[IDXW-1:0] == IDXW'(i)) w_rd_word = r_regs[i];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_wcnt_nxt    = r_wcnt;
      w_pready_nxt  = 1'b0;
      w_pslverr_nxt = 1'b0;
      w_prdata_nxt  = '0;
      w_accept      = 1'b0;
      w_wr_en       = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (psel && !penable) begin
               w_accept    = 1'b1;
               w_state_nxt = ST_ACCESS;
               w_wcnt_nxt  = c_wait;
               // Zero-wait transfers must complete in the first access cycle.
               if (c_wait == 8'd0) begin
                  w_pready_nxt  = 1'b1;
                  w_pslverr_nxt = w_err;
                  w_prdata_nxt  = (w_err || pwrite) ? '0 : w_rd_word;
               end
            end
         end
         ST_ACCESS: begin
            if (r_pready) begin
               w_wr_en     = r_pwrite && !r_err;
               w_state_nxt = ST_IDLE;
               w_wcnt_nxt  = 8'd0;
            end else if (!psel) begin
               w_state_nxt = ST_IDLE;
               w_wcnt_nxt  = 8'd0;
            end else if (r_wcnt <= 8'd1) begin
               w_pready_nxt  = 1'b1;
               w_pslverr_nxt = r_err;
               w_prdata_nxt  = (r_err || r_pwrite) ? '0 : r_rdata;
               w_wcnt_nxt    = 8'd0;
            end else begin
               w_wcnt_nxt = r_wcnt - 8'd1;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wcnt    <= 8'd0;
         r_pready  <= 1'b0;
         r_pslverr <= 1'b0;
         r_prdata  <= '0;
         r_index   <= '0;
         r_pwrite  <= 1'b0;
         r_pwdata  <= '0;
         r_err     <= 1'b0;
         r_rdata   <= '0;
      end else begin
         r_wcnt    <= w_wcnt_nxt;
         r_pready  <= w_pready_nxt;
         r_pslverr <= w_pslverr_nxt;
         r_prdata  <= w_prdata_nxt;
         if (w_accept) begin
            r_index  <= w_addr_index[IDXW-1:0];
            r_pwrite <= pwrite;
            r_pwdata <= pwdata;
            r_err    <= w_err;
            r_rdata  <= w_rd_word;
         end
      end
   end

   generate
      for (genvar g = 1; g < NUM_REGS; g++) begin : g_regs
         always_ff @(posedge clk or posedge reset) begin
            if (reset)                                  r_regs[g] <= '0;
            else if (w_wr_en && (r_index == IDXW'(g)))  r_regs[g] <= r_pwdata;
         end
      end
   endgenerate

   assign prdata  = r_prdata;
   assign pready  = r_pready;
   assign pslverr = r_pslverr;

`ifdef APB_RESPONDER_PROTOCOL_CHECK_EN
   logic [ADDR_WIDTH-1:0] r_paddr;
   logic                  r_proto_err;
   logic                  w_viol;

   // Only selected cycles are checked; psel low in ACCESS is a legal abort.
   assign w_viol = ((r_state == ST_ACCESS) && !r_pready && psel &&
                    (!penable || (paddr != r_paddr) || (pwrite != r_pwrite) ||
                     (pwdata != r_pwdata))) ||
                   ((r_state == ST_IDLE) && psel && penable);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_paddr     <= '0;
         r_proto_err <= 1'b0;
      end else begin
         if (w_accept) r_paddr <= paddr;
         if (w_viol)   r_proto_err <= 1'b1;
      end
   end

   assign proto_err = r_proto_err;
`else
   assign proto_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_apb_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_apb_responder: directed bench for apb_responder at 0, 3 and 2 waits.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_apb_responder;

`ifdef APB_RESPONDER_PROTOCOL_CHECK_EN
   localparam logic [31:0] c_exp_pe = 32'd1;
`else
   localparam logic [31:0] c_exp_pe = 32'd0;
`endif

   logic        clk;
   logic        reset;
   logic        psel      [3];
   logic        penable   [3];
   logic        pwrite    [3];
   logic [31:0] paddr     [3];
   logic [31:0] pwdata    [3];
   logic [31:0] prdata    [3];
   logic        pready    [3];
   logic        pslverr   [3];
   logic        proto_err [3];

   int n_checks = 0;
   int n_errors = 0;

   apb_responder #(.WAIT_CYCLES(0)) u_dut_w0 (
      .clk(clk), .reset(reset), .psel(psel[0]), .penable(penable[0]),
      .paddr(paddr[0]), .pwrite(pwrite[0]), .pwdata(pwdata[0]),
      .prdata(prdata[0]), .pready(pready[0]), .pslverr(pslverr[0]),
      .proto_err(proto_err[0]));

   apb_responder #(.WAIT_CYCLES(3)) u_dut_w3 (
      .clk(clk), .reset(reset), .psel(psel[1]), .penable(penable[1]),
      .paddr(paddr[1]), .pwrite(pwrite[1]), .pwdata(pwdata[1]),
      .prdata(prdata[1]), .pready(pready[1]), .pslverr(pslverr[1]),
      .proto_err(proto_err[1]));

   apb_responder #(.WAIT_CYCLES(2)) u_dut_w2 (
      .clk(clk), .reset(reset), .psel(psel[2]), .penable(penable[2]),
      .paddr(paddr[2]), .pwrite(pwrite[2]), .pwdata(pwdata[2]),
      .prdata(prdata[2]), .pready(pready[2]), .pslverr(pslverr[2]),
      .proto_err(proto_err[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic go_idle(input int k);
      @(negedge clk);
      psel[k]    = 1'b0;
      penable[k] = 1'b0;
   endtask

   // Leaves psel/penable high after completion so a following call is back-to-back.
   task automatic apb_xfer(input int k, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, output logic [31:0] rd,
                           output logic err, output int lat);
      @(negedge clk);
      psel[k]    = 1'b1;
      penable[k] = 1'b0;
      paddr[k]   = addr;
      pwrite[k]  = wr;
      pwdata[k]  = wdata;
      @(negedge clk);
      penable[k] = 1'b1;
      lat = 1;
      while (!pready[k] && lat < 50) begin
         @(negedge clk);
         lat++;
      end
      rd  = prdata[k];
      err = pslverr[k];
   endtask

   task automatic do_xfer(input string tag, input int k, input logic wr,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rd, input logic exp_err, input int exp_lat);
      logic [31:0] rd;
      logic        err;
      int          lat;
      apb_xfer(k, wr, addr, wdata, rd, err, lat);
      check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
      check({tag, "_err"}, {31'd0, err}, {31'd0, exp_err});
      check({tag, "_rd"}, rd, exp_rd);
   endtask

   initial begin
      logic seen;
      reset = 1'b1;
      for (int k = 0; k < 3; k++) begin
         psel[k] = 1'b0; penable[k] = 1'b0; pwrite[k] = 1'b0;
         paddr[k] = '0;  pwdata[k] = '0;
      end
      repeat (3) @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         check("rst_pready", {31'd0, pready[k]}, 32'd0);
         check("rst_pslverr", {31'd0, pslverr[k]}, 32'd0);
         check("rst_prdata", prdata[k], 32'd0);
         check("rst_proto_err", {31'd0, proto_err[k]}, 32'd0);
      end
      reset = 1'b0;

      // Zero-wait write then back-to-back read, then decode errors.
      do_xfer("w0_wr4",    0, 1'b1, 32'h4,  32'hDEADBEEF, 32'h0,        1'b0, 1);
      do_xfer("w0_rd4",    0, 1'b0, 32'h4,  32'h0,        32'hDEADBEEF, 1'b0, 1);
      do_xfer("w0_wr0",    0, 1'b1, 32'h0,  32'h1234,     32'h0,        1'b1, 1);
      do_xfer("w0_wr40",   0, 1'b1, 32'h40, 32'h77,       32'h0,        1'b1, 1);
      do_xfer("w0_wr44",   0, 1'b1, 32'h44, 32'h99,       32'h0,        1'b1, 1);
      do_xfer("w0_rd6",    0, 1'b0, 32'h6,  32'h0,        32'h0,        1'b1, 1);
      do_xfer("w0_rd0",    0, 1'b0, 32'h0,  32'h0,        32'hA9B00001, 1'b0, 1);
      do_xfer("w0_rd4b",   0, 1'b0, 32'h4,  32'h0,        32'hDEADBEEF, 1'b0, 1);
      do_xfer("w0_wr3c",   0, 1'b1, 32'h3C, 32'hCAFE0F0F, 32'h0,        1'b0, 1);
      do_xfer("w0_rd3c",   0, 1'b0, 32'h3C, 32'h0,        32'hCAFE0F0F, 1'b0, 1);
      go_idle(0);
      check("w0_pready_drop", {31'd0, pready[0]}, 32'd0);

      // Three wait states: completion in T4, for exactly one cycle.
      do_xfer("w3_rd0", 1, 1'b0, 32'h0, 32'h0, 32'hA9B00001, 1'b0, 4);
      go_idle(1);
      check("w3_pready_one", {31'd0, pready[1]}, 32'd0);
      check("w3_prdata_idle", prdata[1], 32'd0);

      // Two wait states: abort in T1 leaves the register untouched.
      @(negedge clk);
      psel[2] = 1'b1; penable[2] = 1'b0; paddr[2] = 32'h8; pwrite[2] = 1'b1;
      pwdata[2] = 32'h55;
      @(negedge clk);
      psel[2] = 1'b0;
      seen = 1'b0;
      repeat (5) begin
         @(negedge clk);
         if (pready[2]) seen = 1'b1;
      end
      check("w2_abort_pready", {31'd0, seen}, 32'd0);
      do_xfer("w2_rd8", 2, 1'b0, 32'h8, 32'h0, 32'h0, 1'b0, 3);
      do_xfer("w2_wrc", 2, 1'b1, 32'hC, 32'h11, 32'h0, 1'b0, 3);
      do_xfer("w2_rdc", 2, 1'b0, 32'hC, 32'h0, 32'h11, 1'b0, 3);
      go_idle(2);

      // Reset in the completion cycle of a waited write.
      @(negedge clk);
      psel[1] = 1'b1; penable[1] = 1'b0; paddr[1] = 32'h8; pwrite[1] = 1'b1;
      pwdata[1] = 32'h66;
      @(negedge clk);
      penable[1] = 1'b1;
      repeat (3) @(negedge clk);
      check("w3_pre_rst_pready", {31'd0, pready[1]}, 32'd1);
      reset = 1'b1;
      #1;
      check("w3_rst_pready", {31'd0, pready[1]}, 32'd0);
      check("w3_rst_pslverr", {31'd0, pslverr[1]}, 32'd0);
      check("w3_rst_prdata", prdata[1], 32'd0);
      @(negedge clk);
      reset = 1'b0;
      psel[1] = 1'b0; penable[1] = 1'b0;
      do_xfer("w3_rd8_after_rst", 1, 1'b0, 32'h8, 32'h0, 32'h0, 1'b0, 4);
      do_xfer("w0_rd4_after_rst", 0, 1'b0, 32'h4, 32'h0, 32'h0, 1'b0, 1);
      go_idle(0);
      go_idle(1);

      // paddr changes during wait states; the latched address still decides.
      @(negedge clk);
      psel[1] = 1'b1; penable[1] = 1'b0; paddr[1] = 32'h4; pwrite[1] = 1'b1;
      pwdata[1] = 32'h1;
      @(negedge clk);
      penable[1] = 1'b1;
      @(negedge clk);
      paddr[1] = 32'h8;
      begin
         int n;
         n = 2;
         while (!pready[1] && n < 50) begin
            @(negedge clk);
            n++;
         end
         check("pe_xfer_lat", 32'(n), 32'd4);
      end
      check("pe_set", {31'd0, proto_err[1]}, c_exp_pe);
      go_idle(1);
      do_xfer("pe_rd4", 1, 1'b0, 32'h4, 32'h0, 32'h1, 1'b0, 4);
      do_xfer("pe_rd8", 1, 1'b0, 32'h8, 32'h0, 32'h0, 1'b0, 4);
      check("pe_sticky", {31'd0, proto_err[1]}, c_exp_pe);
      go_idle(1);

      // psel+penable from IDLE must not start a transfer.
      @(negedge clk);
      psel[0] = 1'b1; penable[0] = 1'b1; paddr[0] = 32'h0; pwrite[0] = 1'b0;
      seen = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (pready[0]) seen = 1'b1;
      end
      check("idle_en_no_xfer", {31'd0, seen}, 32'd0);
      check("idle_en_proto_err", {31'd0, proto_err[0]}, c_exp_pe);
      go_idle(0);

      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("pe_cleared", {31'd0, proto_err[1]}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
